frame_streamer: RTL
===================

FRAME_STREAMER -- requirements
Module: frame_streamer

Interface
REQ-001 SHALL take parameter W, default PX_WIDTH; pixels per line.
REQ-002 SHALL take parameter H, default PX_HEIGHT; lines per frame.
REQ-003 SHALL take parameter AW, default 16; frame-buffer address width; W*H <= 2**AW.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on rising edge.
REQ-005 SHALL have port clr, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port frame_start, input, 1: one-cycle pulse requesting a frame scan.
REQ-007 SHALL have port rd_addr, output, AW: frame-buffer read address, i.e. renderer second read port.
REQ-008 SHALL have port rd_data, input, 3: pixel code, valid exactly 1 cycle after rd_addr.
REQ-009 SHALL have port pix_code, output, 3: streamed pixel code.
REQ-010 SHALL have port pix_valid, output, 1: pix_code/pix_eol/pix_eof valid.
REQ-011 SHALL have port pix_ready, input, 1: consumer accepts when pix_valid && pix_ready.
REQ-012 SHALL have port pix_eol, output, 1: current pixel is last of its line.
REQ-013 SHALL have port pix_eof, output, 1: current pixel is last of frame.
REQ-014 SHALL have port busy, output, 1: scan in progress.
REQ-015 SHALL have port overrun, output, 1: sticky; frame_start arrived while busy.
REQ-016 SHALL have port frame_cnt, output, 16: completed frames, wraps 0xFFFF->0.
REQ-017 SHALL have port checksum, output, 16: last frame checksum (see Configuration).

Function
REQ-018 SHALL implement states IDLE, ADDR, DATA, OUT.
REQ-019 SHALL, in IDLE with frame_start=1, clear x,y and rd_addr to 0 and go to ADDR.
REQ-020 SHALL go ADDR->DATA unconditionally; rd_addr = y*W+x held stable through ADDR and DATA.
REQ-021 SHALL, in DATA, register rd_data into pix_code, set pix_valid=1, set pix_eol=(x==W-1), set pix_eof=(x==W-1 && y==H-1), and go to OUT.
REQ-022 SHALL, in OUT, hold pix_code/pix_eol/pix_eof/pix_valid stable until pix_ready=1.
REQ-023 SHALL, on OUT handshake that is not the last pixel, drop pix_valid, advance x (wrap to 0 with y+1 at W-1), increment rd_addr by 1, and go to ADDR.
REQ-024 SHALL, on OUT handshake for the last pixel, drop pix_valid, increment frame_cnt, and return to IDLE.
REQ-025 SHALL deliver the first pix_valid 3 cycles after frame_start, giving a best-case throughput of 1 pixel per 3 cycles.
REQ-026 SHALL assert busy in every state except IDLE.
REQ-027 SHALL ignore frame_start while busy and set overrun; the current scan SHALL continue unaffected.
REQ-028 SHALL ignore frame_start coincident with the last-pixel handshake, with overrun set; IDLE SHALL be reached regardless.
REQ-029 SHALL NOT let pix_ready matter outside OUT.

Reset
REQ-030 SHALL, when clr=0, asynchronously force state IDLE, x=y=0, rd_addr=0, pix_code=0, pix_valid=0, pix_eol=0, pix_eof=0, overrun=0, frame_cnt=0, checksum=0.
REQ-031 SHALL abandon a scan interrupted by reset mid-frame without incrementing frame_cnt; the first frame_start after release SHALL restart at address 0.

Configuration
REQ-032 SHALL, with FRAME_STREAMER_CHECKSUM_EN defined, accumulate a 16-bit wrapping sum of each handshaked pix_code, cleared at scan start and copied to checksum on the last-pixel handshake.
REQ-033 SHALL, without FRAME_STREAMER_CHECKSUM_EN, tie checksum to 0 and include no accumulator.

Structure
REQ-034 SHALL take PX_WIDTH, PX_HEIGHT and the state encoding from the shared constants file consts.v.
REQ-035 SHALL be a single module with no sub-module; the x/y counter is inline.

Verification (bench with W=4, H=3)
REQ-036 SHALL cover: memory code = addr%8, pix_ready=1, one frame_start -> 12 pixels 0,1,..,7,0,1,2,3; eol on pixels 3,7,11; eof on pixel 11; frame_cnt=1.
REQ-037 SHALL cover: pix_ready low 5 cycles at pixel 2 -> pix_code=2 held stable, no pixel lost or duplicated.
REQ-038 SHALL cover: frame_start pulsed at pixel 6 -> overrun=1, frame still 12 pixels, frame_cnt=1.
REQ-039 SHALL cover: clr=0 at pixel 5, then frame_start -> first pixel code 0, rd_addr=0, frame_cnt=0 before the frame completes.
REQ-040 SHALL cover: checksum enabled, codes addr%8 -> checksum=34 after the frame; disabled -> checksum=0.
REQ-041 SHALL cover: frame_cnt preloaded by 65535 frames, plus one frame -> frame_cnt=0.

Source files
------------

// File: rtl/frame_streamer_pkg.sv
// frame_streamer_pkg -- constants shared by the frame streamer slice.
//   PX_WIDTH / PX_HEIGHT : default frame geometry (pixels per line, lines per frame)
//   PIX_CW               : pixel code width
//   state_t              : scan FSM encoding
//   cnt_w()              : counter width for a 0..n-1 range (never below 1 bit)
package frame_streamer_pkg;

  localparam int PX_WIDTH  = 160;
  localparam int PX_HEIGHT = 120;
  localparam int PIX_CW    = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/frame_streamer_if.sv
// frame_streamer_if -- pixel stream from the frame streamer to its consumer.
//   pix_code  : streamed pixel code
//   pix_valid : code/eol/eof valid
//   pix_ready : consumer accepts when pix_valid && pix_ready
//   pix_eol   : current pixel is last of its line
//   pix_eof   : current pixel is last of the frame
// master = streamer side, slave = consumer side.
interface frame_streamer_if;
  import frame_streamer_pkg::*;

  logic [PIX_CW-1:0] pix_code;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_eol;
  logic              pix_eof;

  modport master (output pix_code, pix_valid, pix_eol, pix_eof, input  pix_ready);
  modport slave  (input  pix_code, pix_valid, pix_eol, pix_eof, output pix_ready);
endinterface

// File: rtl/frame_streamer.sv
// frame_streamer -- scans a W x H frame buffer in raster order through a
// read port with one cycle of latency and streams the codes out over a
// valid/ready pixel interface, one pixel per ADDR->DATA->OUT round.
//   clk         : clock, rising edge
//   clr         : asynchronous active-low reset
//   frame_start : one-cycle pulse requesting a scan (ignored while busy)
//   rd_addr     : frame-buffer read address (y*W + x)
//   rd_data     : pixel code, valid one cycle after rd_addr
//   pix         : pixel stream (frame_streamer_if.master)
//   busy        : scan in progress
//   overrun     : sticky, frame_start seen while busy
//   frame_cnt   : completed frames, wrapping
//   checksum    : 16-bit sum of the last frame's codes
// Build option: FRAME_STREAMER_CHECKSUM_EN enables the checksum accumulator;
// without it checksum is tied to 0.
module frame_streamer
  import frame_streamer_pkg::*;
#(
  parameter int W  = PX_WIDTH,
  parameter int H  = PX_HEIGHT,
  parameter int AW = 16
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 frame_start,
  output logic [AW-1:0]        rd_addr,
  input  logic [PIX_CW-1:0]    rd_data,
  frame_streamer_if.master     pix,
  output logic                 busy,
  output logic                 overrun,
  output logic [15:0]          frame_cnt,
  output logic [15:0]          checksum
);

  localparam int XW = cnt_w(W);
  localparam int YW = cnt_w(H);
  localparam logic [XW-1:0] X_LAST = XW'(W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(H - 1);

  state_t            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [PIX_CW-1:0] code_q, code_d;
  logic              vld_q, vld_d;
  logic              eol_q, eol_d;
  logic              eof_q, eof_d;
  logic              ovr_q, ovr_d;
  logic [15:0]       fcnt_q, fcnt_d;
`ifdef FRAME_STREAMER_CHECKSUM_EN
  logic [15:0]       sum_q, sum_d;
  logic [15:0]       csum_q, csum_d;
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    code_d  = code_q;
    vld_d   = vld_q;
    eol_d   = eol_q;
    eof_d   = eof_q;
    // Any request outside IDLE is dropped but remembered, including one
    // landing on the last-pixel handshake.
    ovr_d   = ovr_q | (frame_start && (state_q != S_IDLE));
    fcnt_d  = fcnt_q;
`ifdef FRAME_STREAMER_CHECKSUM_EN
    sum_d   = sum_q;
    csum_d  = csum_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
`ifdef FRAME_STREAMER_CHECKSUM_EN
          sum_d   = '0;
`endif
          state_d = S_ADDR;
        end
      end
      // rd_addr is already stable; the read completes during DATA.
      S_ADDR: state_d = S_DATA;
      S_DATA: begin
        code_d  = rd_data;
        vld_d   = 1'b1;
        eol_d   = (x_q == X_LAST);
        eof_d   = (x_q == X_LAST) && (y_q == Y_LAST);
        state_d = S_OUT;
      end
      S_OUT: begin
        if (pix.pix_ready) begin
          vld_d = 1'b0;
`ifdef FRAME_STREAMER_CHECKSUM_EN
          sum_d = sum_q + 16'(code_q);
`endif
          if (eof_q) begin
            fcnt_d  = fcnt_q + 16'd1;
`ifdef FRAME_STREAMER_CHECKSUM_EN
            csum_d  = sum_q + 16'(code_q);
`endif
            state_d = S_IDLE;
          end else begin
            // Raster order makes y*W+x a plain increment.
            if (eol_q) begin
              x_d = '0;
              y_d = y_q + YW'(1);
            end else begin
              x_d = x_q + XW'(1);
            end
            addr_d  = addr_q + AW'(1);
            state_d = S_ADDR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      code_q  <= '0;
      vld_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      ovr_q   <= 1'b0;
      fcnt_q  <= '0;
`ifdef FRAME_STREAMER_CHECKSUM_EN
      sum_q   <= '0;
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      code_q  <= code_d;
      vld_q   <= vld_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
      ovr_q   <= ovr_d;
      fcnt_q  <= fcnt_d;
`ifdef FRAME_STREAMER_CHECKSUM_EN
      sum_q   <= sum_d;
      csum_q  <= csum_d;
`endif
    end
  end

  assign rd_addr       = addr_q;
  assign pix.pix_code  = code_q;
  assign pix.pix_valid = vld_q;
  assign pix.pix_eol   = eol_q;
  assign pix.pix_eof   = eof_q;
  assign busy          = (state_q != S_IDLE);
  assign overrun       = ovr_q;
  assign frame_cnt     = fcnt_q;
`ifdef FRAME_STREAMER_CHECKSUM_EN
  assign checksum      = csum_q;
`else
  assign checksum      = 16'd0;
`endif

endmodule
